// File: rtl/uart_byte_rx_if.sv
// Byte handshake between the UART receiver and the packet handler.
// The master holds the byte and its valid flag; the slave returns ready.
interface uart_byte_rx_if;
  logic [7:0] rx_frame;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_frame, output rx_valid, input rx_ready);
  modport slave  (input rx_frame, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receive front end: synchronizes rx_in, assembles bytes LSB first
// and presents them on a one-deep valid/ready holding register.
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  uart_byte_rx_if.master        rx_bus,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [7:0]              shift_q, shift_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;
  logic                    deliver;
  logic                    ferr_d;
  logic [7:0]              frame_q;
  logic                    valid_q;
  logic                    take;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        // A stuck-low line must return high before a new start bit counts.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign take = valid_q && rx_bus.rx_ready;

  // A completed byte loads if the slot is empty or drains this same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q   <= '0;
      valid_q   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      overrun   <= deliver && valid_q && !rx_bus.rx_ready;
      if (deliver && (!valid_q || take)) begin
        frame_q <= shift_q;
        valid_q <= 1'b1;
      end else if (take) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_frame = frame_q;
  assign rx_bus.rx_valid = valid_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clocks per bit: table of single
// characters plus hand-written multi-cycle sequences.
module tb_uart_byte_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_in = 1'b1;
  logic frame_err, overrun, busy;

  uart_byte_rx_if bus ();

  uart_byte_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_bus    (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_frame);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) both_cnt++;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_bytes;
    logic [7:0] exp_byte;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is positioned #1 after a rising edge; so is the return point.
  task automatic send_char(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base_b, base_f, base_o, n;
  logic [7:0] seen_frame;
  logic seen_after, saw_busy;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 8'h80, 0};
    vecs[4] = '{8'h01, 1'b1, 1, 8'h01, 0};
    vecs[5] = '{8'h3C, 1'b0, 0, 8'h00, 1};

    bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_frame", int'(bus.rx_frame), 0);
    check("reset_valid", int'(bus.rx_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_ovr", int'(overrun), 0);
    rst = 1'b0;
    idle(5);

    // Single byte with latency and one-cycle valid
    n = 0;
    fork
      send_char(8'hA5, 1'b1);
      begin
        while (!bus.rx_valid && n < 300) begin
          @(posedge clk);
          #1;
          n++;
        end
        seen_frame = bus.rx_frame;
        @(posedge clk);
        #1;
        seen_after = bus.rx_valid;
      end
    join
    check("latency_in_range", int'(n >= 153 && n <= 156), 1);
    check("single_frame", int'(seen_frame), 8'hA5);
    check("single_valid_one_cycle", int'(seen_after), 0);
    idle(20);

    for (int v = 0; v < 6; v++) begin
      base_b = got_q.size();
      base_f = ferr_cnt;
      base_o = ovr_cnt;
      send_char(vecs[v].data, vecs[v].stop_bit);
      if (!vecs[v].stop_bit) begin
        rx_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
      end
      idle(20);
      check($sformatf("vec%0d_bytes", v), got_q.size() - base_b, vecs[v].exp_bytes);
      if (vecs[v].exp_bytes > 0)
        check($sformatf("vec%0d_data", v), int'(got_q[base_b]), int'(vecs[v].exp_byte));
      check($sformatf("vec%0d_ferr", v), ferr_cnt - base_f, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ovr_cnt - base_o, 0);
    end

    // Glitch shorter than half a bit
    base_b = got_q.size();
    base_f = ferr_cnt;
    saw_busy = 1'b0;
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      saw_busy |= busy;
    end
    idle(20);
    check("glitch_busy_pulse", int'(saw_busy), 1);
    check("glitch_idle", int'(busy), 0);
    check("glitch_no_byte", got_q.size() - base_b, 0);
    check("glitch_no_ferr", ferr_cnt - base_f, 0);

    // Framing error then recovery
    base_b = got_q.size();
    base_f = ferr_cnt;
    send_char(8'h3C, 1'b0);
    rx_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("break_busy_held", int'(busy), 1);
    check("break_ferr_once", ferr_cnt - base_f, 1);
    check("break_no_byte", got_q.size() - base_b, 0);
    idle(20);
    check("break_released", int'(busy), 0);
    send_char(8'h5A, 1'b1);
    idle(20);
    check("after_break_bytes", got_q.size() - base_b, 1);
    if (got_q.size() > base_b) check("after_break_data", int'(got_q[base_b]), 8'h5A);

    // Overrun with consumer stalled
    base_b = got_q.size();
    base_o = ovr_cnt;
    bus.rx_ready = 1'b0;
    send_char(8'h11, 1'b1);
    send_char(8'h22, 1'b1);
    idle(20);
    check("ovr_valid_held", int'(bus.rx_valid), 1);
    check("ovr_frame_kept", int'(bus.rx_frame), 8'h11);
    check("ovr_pulse_once", ovr_cnt - base_o, 1);
    check("ovr_no_transfer", got_q.size() - base_b, 0);
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("ovr_drain_valid", int'(bus.rx_valid), 0);
    check("ovr_drain_count", got_q.size() - base_b, 1);
    if (got_q.size() > base_b) check("ovr_drain_data", int'(got_q[base_b]), 8'h11);

    // Back-to-back stream
    base_b = got_q.size();
    base_f = ferr_cnt;
    base_o = ovr_cnt;
    for (int i = 1; i <= 4; i++) send_char(8'(i), 1'b1);
    idle(20);
    check("stream_count", got_q.size() - base_b, 4);
    if (got_q.size() >= base_b + 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("stream_byte%0d", i), int'(got_q[base_b+i]), i + 1);
      check("stream_word", int'({got_q[base_b+2], got_q[base_b+3]}), 16'h0304);
    end
    check("stream_no_ferr", ferr_cnt - base_f, 0);
    check("stream_no_ovr", ovr_cnt - base_o, 0);

    // Reset during data bit 4 of 0xFF
    base_b = got_q.size();
    rx_in = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (72) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(bus.rx_valid), 0);
    check("midrst_frame", int'(bus.rx_frame), 0);
    idle(100);
    check("midrst_no_byte", got_q.size() - base_b, 0);
    send_char(8'h42, 1'b1);
    idle(20);
    check("midrst_next_count", got_q.size() - base_b, 1);
    if (got_q.size() > base_b) check("midrst_next_data", int'(got_q[base_b]), 8'h42);

    check("ferr_ovr_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
